// File: rtl/sa_result_wb_buffer.sv
// Result write-back buffer between the systolic array accumulator port and the
// matrix register file: row FIFO, per-register pending mask, sticky completion.
package xif_pkg;
  localparam int X_ID_WIDTH = 4;
endpackage

module sa_result_wb_buffer #(
  parameter int MESH_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS     = 8,
  parameter int DEPTH      = 4,
  localparam int RLEN      = DATA_WIDTH * MESH_WIDTH,
  localparam int N_ROWS    = MESH_WIDTH,
  localparam int AW        = $clog2(N_REGS),
  localparam int RAW       = $clog2(N_ROWS),
  localparam int IDW       = xif_pkg::X_ID_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AW-1:0]   in_waddr_i,
  input  logic [RAW-1:0]  in_wrowaddr_i,
  input  logic [RLEN-1:0] in_wdata_i,
  input  logic            in_we_i,
  input  logic            in_wlast_i,
  input  logic [IDW-1:0]  in_id_i,
  output logic            in_wready_o,
  output logic [AW-1:0]   out_waddr_o,
  output logic [RAW-1:0]  out_wrowaddr_o,
  output logic [RLEN-1:0] out_wdata_o,
  output logic            out_we_o,
  output logic            out_wlast_o,
  input  logic            out_wready_i,
  output logic [N_REGS-1:0] pending_regs_o,
  output logic            empty_o,
  output logic            finished_o,
  output logic [IDW-1:0]  finished_instr_id_o,
  input  logic            finished_ack_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]   r_waddr [DEPTH];
  logic [RAW-1:0]  r_wrow  [DEPTH];
  logic [RLEN-1:0] r_wdata [DEPTH];
  logic            r_wlast [DEPTH];
  logic [IDW-1:0]  r_id    [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_pend  [N_REGS];
  logic            r_fin;
  logic [IDW-1:0]  r_fin_id;

  logic w_full, w_empty, w_stall, w_push, w_pop;
  logic [N_REGS-1:0] w_inc, w_dec;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Hold a second last-row until the previous completion is acknowledged.
  assign w_stall = r_wlast[r_rptr] & r_fin & ~finished_ack_i;
  assign w_push  = in_we_i & ~w_full;
  assign w_pop   = out_we_o & out_wready_i;

  assign in_wready_o         = ~w_full;
  assign empty_o             = w_empty;
  assign out_we_o            = ~w_empty & ~w_stall;
  assign out_waddr_o         = r_waddr[r_rptr];
  assign out_wrowaddr_o      = r_wrow[r_rptr];
  assign out_wdata_o         = r_wdata[r_rptr];
  assign out_wlast_o         = r_wlast[r_rptr];
  assign finished_o          = r_fin;
  assign finished_instr_id_o = r_fin_id;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_waddr[r_wptr] <= in_waddr_i;
      r_wrow[r_wptr]  <= in_wrowaddr_i;
      r_wdata[r_wptr] <= in_wdata_i;
      r_wlast[r_wptr] <= in_wlast_i;
      r_id[r_wptr]    <= in_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar r = 0; r < N_REGS; r++) begin : g_pend
    assign w_inc[r]          = w_push & (in_waddr_i == AW'(r));
    assign w_dec[r]          = w_pop & (r_waddr[r_rptr] == AW'(r));
    assign pending_regs_o[r] = (r_pend[r] != '0);

    always_ff @(posedge clk_i) begin
      if (!rst_ni)                 r_pend[r] <= '0;
      else if (w_inc[r] & ~w_dec[r]) r_pend[r] <= r_pend[r] + CW'(1);
      else if (w_dec[r] & ~w_inc[r]) r_pend[r] <= r_pend[r] - CW'(1);
    end
  end

  // A last-row pop beats a same-cycle acknowledge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fin    <= 1'b0;
      r_fin_id <= '0;
    end else if (w_pop & r_wlast[r_rptr]) begin
      r_fin    <= 1'b1;
      r_fin_id <= r_id[r_rptr];
    end else if (finished_ack_i) begin
      r_fin    <= 1'b0;
      r_fin_id <= '0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_push && w_full));
      assert (!(w_pop && w_empty));
      for (int r = 0; r < N_REGS; r++) begin
        assert (!(w_inc[r] && !w_dec[r] && r_pend[r] == CW'(DEPTH)));
        assert (!(w_dec[r] && !w_inc[r] && r_pend[r] == '0));
      end
    end
  end
`endif

endmodule

// File: tb/tb_sa_result_wb_buffer.sv
// Randomized + directed bench for sa_result_wb_buffer against a queue-based model.
module tb_sa_result_wb_buffer;
  localparam int MW = 4, DW = 32, NR = 8, DEPTH = 4;
  localparam int IDW = xif_pkg::X_ID_WIDTH;
  localparam int RLEN = DW * MW, AW = $clog2(NR), RAW = $clog2(MW);

  typedef struct {
    logic [AW-1:0]   a;
    logic [RAW-1:0]  ra;
    logic [RLEN-1:0] d;
    logic            last;
    logic [IDW-1:0]  id;
  } ent_t;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic [AW-1:0] in_waddr_i = '0;
  logic [RAW-1:0] in_wrowaddr_i = '0;
  logic [RLEN-1:0] in_wdata_i = '0;
  logic in_we_i = 1'b0, in_wlast_i = 1'b0, out_wready_i = 1'b0, finished_ack_i = 1'b0;
  logic [IDW-1:0] in_id_i = '0;
  logic in_wready_o, out_we_o, out_wlast_o, empty_o, finished_o;
  logic [AW-1:0] out_waddr_o;
  logic [RAW-1:0] out_wrowaddr_o;
  logic [RLEN-1:0] out_wdata_o;
  logic [NR-1:0] pending_regs_o;
  logic [IDW-1:0] finished_instr_id_o;

  sa_result_wb_buffer #(.MESH_WIDTH(MW), .DATA_WIDTH(DW), .N_REGS(NR), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_waddr_i(in_waddr_i), .in_wrowaddr_i(in_wrowaddr_i), .in_wdata_i(in_wdata_i),
    .in_we_i(in_we_i), .in_wlast_i(in_wlast_i), .in_id_i(in_id_i), .in_wready_o(in_wready_o),
    .out_waddr_o(out_waddr_o), .out_wrowaddr_o(out_wrowaddr_o), .out_wdata_o(out_wdata_o),
    .out_we_o(out_we_o), .out_wlast_o(out_wlast_o), .out_wready_i(out_wready_i),
    .pending_regs_o(pending_regs_o), .empty_o(empty_o), .finished_o(finished_o),
    .finished_instr_id_o(finished_instr_id_o), .finished_ack_i(finished_ack_i)
  );

  always #5 clk = ~clk;

  // reference model: buffered rows in arrival order plus the completion register
  ent_t q[$];
  logic m_fin = 1'b0;
  logic [IDW-1:0] m_id = '0;

  int n_chk = 0, n_pass = 0;
  int wr_mode = 1;
  bit tog = 1'b0;

  task automatic chk(input string tag, input logic [RLEN-1:0] got, input logic [RLEN-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic pick_wr();
    case (wr_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin tog = ~tog; return tog; end
      default: return ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  function automatic ent_t mk(input int a, input int ra, input bit last, input int id);
    ent_t e;
    e.a = AW'(a); e.ra = RAW'(ra); e.last = last; e.id = IDW'(id);
    e.d = {$urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  // One clock: drive, check against model, advance model at the edge.
  task automatic cyc(input ent_t r, input logic we, input logic wr, input logic ack,
                     input logic rst, output logic acc);
    logic exp_we, push, pop;
    logic [NR-1:0] pend;
    ent_t h;
    in_waddr_i = r.a; in_wrowaddr_i = r.ra; in_wdata_i = r.d;
    in_wlast_i = r.last; in_id_i = r.id; in_we_i = we;
    out_wready_i = wr; finished_ack_i = ack; rst_ni = ~rst;
    #1;
    exp_we = (q.size() > 0) && !(q[0].last && m_fin && !ack);
    pend = '0;
    foreach (q[i]) pend[q[i].a] = 1'b1;
    if (!rst) begin
      chk("in_wready", in_wready_o, q.size() != DEPTH);
      chk("out_we", out_we_o, exp_we);
      chk("empty", empty_o, q.size() == 0);
      chk("pending", pending_regs_o, pend);
      chk("finished", finished_o, m_fin);
      chk("fin_id", finished_instr_id_o, m_id);
      if (q.size() > 0) begin
        chk("out_waddr", out_waddr_o, q[0].a);
        chk("out_wrow", out_wrowaddr_o, q[0].ra);
        chk("out_wdata", out_wdata_o, q[0].d);
        chk("out_wlast", out_wlast_o, q[0].last);
      end
    end
    push = we && (q.size() != DEPTH);
    pop  = exp_we && wr;
    acc  = push && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_fin = 1'b0; m_id = '0;
    end else begin
      if (pop) h = q.pop_front();
      if (pop && h.last) begin m_fin = 1'b1; m_id = h.id; end
      else if (ack) begin m_fin = 1'b0; m_id = '0; end
      if (push) q.push_back(r);
    end
    @(negedge clk);
  endtask

  task automatic send(input ent_t r);
    logic acc;
    int n = 0;
    do begin
      cyc(r, 1'b1, pick_wr(), 1'b0, 1'b0, acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input logic ack);
    logic acc;
    for (int i = 0; i < n; i++) cyc(mk(0, 0, 0, 0), 1'b0, pick_wr(), ack, 1'b0, acc);
  endtask

  initial begin
    logic acc, have;
    ent_t r;
    #1;
    cyc(mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cyc(mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b0);

    // single instruction to reg 5, id 7
    wr_mode = 1;
    for (int i = 0; i < 4; i++) send(mk(5, i, i == 3, 7));
    idle(3, 1'b0);

    // back-pressure: 5th row held upstream while full
    wr_mode = 0;
    for (int i = 0; i < 4; i++) send(mk($urandom_range(0, NR - 1), i, 0, 3));
    r = mk(6, 0, 0, 3);
    for (int i = 0; i < 3; i++) cyc(r, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    wr_mode = 1;
    send(r);
    idle(6, 1'b0);
    idle(1, 1'b1);

    // overlapped reg 2 instructions, toggling ready; id 2 stalls on unacked id 1
    wr_mode = 2;
    for (int i = 0; i < 8; i++) send(mk(2, i % 4, (i % 4) == 3, (i < 4) ? 1 : 2));
    idle(6, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);

    // simultaneous push/pop at count 2, different registers
    wr_mode = 0;
    send(mk(1, 0, 0, 4));
    send(mk(1, 1, 0, 4));
    cyc(mk(3, 0, 0, 5), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    wr_mode = 1;
    idle(4, 1'b0);

    // mid-operation reset with rows buffered and finished set
    wr_mode = 0;
    for (int i = 0; i < 3; i++) send(mk(i + 4, i, 0, 6));
    cyc(mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b0);

    // randomized traffic, rows held upstream until accepted
    wr_mode = 3;
    have = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!have) begin
        r = mk($urandom_range(0, NR - 1), $urandom_range(0, MW - 1),
               $urandom_range(0, 3) == 0, $urandom);
        have = ($urandom_range(0, 9) < 7);
      end
      cyc(r, have, pick_wr(), $urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0, acc);
      if (acc) have = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sa_result_wb_buffer.md
Name: sa_result_wb_buffer

Overview:
- Sits directly downstream of the systolic array's accumulator-out write port and upstream of the matrix register file write port.
- Buffers result rows in a small FIFO so the array is decoupled from write-port back-pressure.
- Publishes a per-register pending-write mask so the issue logic can stall readers of registers with writes still in flight.
- Raises a sticky completion flag with the instruction ID once the last row of a result has been written to the register file.

Parameters:
- MESH_WIDTH, 4, rows per matrix register; must be at least 2.
- DATA_WIDTH, 32, bits per element.
- N_REGS, 8, number of matrix registers.
- DEPTH, 4, number of FIFO row entries; must be at least 2 (any integer value).
- RLEN (localparam), DATA_WIDTH*MESH_WIDTH, row width.
- N_ROWS (localparam), MESH_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- in_waddr_i  in  $clog2(N_REGS)  destination register of the incoming row.
- in_wrowaddr_i  in  $clog2(N_ROWS)  row index of the incoming row.
- in_wdata_i  in  RLEN  row data.
- in_we_i  in  1  incoming row valid.
- in_wlast_i  in  1  incoming row is the last row of its instruction.
- in_id_i  in  xif_pkg::X_ID_WIDTH  instruction ID of the incoming row.
- in_wready_o  out  1  buffer can accept a row.
- out_waddr_o  out  $clog2(N_REGS)  head-entry register address.
- out_wrowaddr_o  out  $clog2(N_ROWS)  head-entry row address.
- out_wdata_o  out  RLEN  head-entry data.
- out_we_o  out  1  head-entry write request.
- out_wlast_o  out  1  head-entry last flag.
- out_wready_i  in  1  register file accepts the write.
- pending_regs_o  out  N_REGS  bit r is set while at least one row for register r is buffered.
- empty_o  out  1  FIFO holds no entries.
- finished_o  out  1  sticky completion flag.
- finished_instr_id_o  out  xif_pkg::X_ID_WIDTH  ID of the completed instruction.
- finished_ack_i  in  1  clears finished_o.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - FIFO pointers and count go to 0; all pending counters go to 0; finished flag and ID go to 0.
  - Output values after reset: in_wready_o=1, out_we_o=0, empty_o=1, pending_regs_o=0, finished_o=0, finished_instr_id_o=0.
  - out_* address and data fields are don't-care while out_we_o=0.
  - A reset asserted mid-operation discards all buffered rows with no completion reported.
- FIFO entry contents: {waddr, wrowaddr, wdata, wlast, id}.
- Push occurs when in_we_i & in_wready_o.
- in_wready_o = (count != DEPTH).
  - No same-cycle pass-through when the FIFO is full: a pop in that cycle does not raise ready.
- Pop occurs when out_we_o & out_wready_i.
- Push and pop may happen in the same cycle whenever count < DEPTH; count is then unchanged.
- Pointers wrap from DEPTH-1 to 0.
- Latency: a row pushed in cycle N is presented on out_* from cycle N+1 at the earliest. out_* fields are driven directly from the head entry, with no extra register stage.
- out_we_o = ~empty & ~stall.
  - stall = head.wlast & finished_q & ~finished_ack_i.
  - This prevents a second completion from overwriting an unacknowledged one.
  - Non-last rows are never stalled.
- out_* fields hold stable while out_we_o=1 and out_wready_i=0.
- Pending counters:
  - One counter per register, width $clog2(DEPTH+1).
  - A push increments the counter of in_waddr_i; a pop decrements the counter of head.waddr.
  - If push and pop target the same register in the same cycle, that counter is unchanged.
  - pending_regs_o[r] = (cnt[r] != 0), driven combinationally from the registered counters.
- Completion:
  - A pop with head.wlast=1 sets finished_q=1 and finished_instr_id_q=head.id in the next cycle.
  - finished_ack_i with no simultaneous last-pop clears finished_q and the ID to 0.
  - If a last-pop and finished_ack_i occur in the same cycle, set wins: the flag stays 1 and the ID is updated to the new one.
- in_wrowaddr_i ordering is not checked; rows are written in arrival order.
- Assertions (simulation only):
  - No push while full.
  - No pop while empty.
  - No pending counter underflows or overflows.

Test Plan:
- Single instruction: push rows 0..3 to reg 5 with id=7 and last on row 3, out_wready_i=1 throughout -> out_we_o rises 1 cycle after the first push; 4 writes with out_wrowaddr_o 0,1,2,3; pending_regs_o=8'b0010_0000 until the last pop; finished_o=1 with ID 7 one cycle after the last pop.
- Back-pressure: out_wready_i=0 while pushing 5 rows with DEPTH=4 -> in_wready_o=0 once count=4; 5th row held upstream; out_* stable; releasing out_wready_i drains rows in FIFO order.
- Overlapped same-register writes: push reg 2 rows 0..3 (id 1), then reg 2 rows 0..3 (id 2), with out_wready_i toggling every cycle -> pending_regs_o[2] stays 1 until the 8th pop, then 0.
- Unacked completion: id 1 finishes with no ack, and id 2's last row reaches the head -> out_we_o=0 for that row; finished_instr_id_o=1; asserting finished_ack_i releases the row and finished_instr_id_o becomes 2 the next cycle.
- Simultaneous push/pop at count=2 to different regs 1 and 3 -> count stays 2; cnt[1] decrements and cnt[3] increments in the same cycle.
- Mid-operation reset with 3 rows buffered and finished_o=1 -> after the reset edge, empty_o=1, pending_regs_o=0, finished_o=0, out_we_o=0, in_wready_o=1.
